pipe_stage_reg: RTL

Parametrised elastic pipeline stage register that replaces the fixed-width, always-loading inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a WIDTH-bit payload between two stages with a valid/ready handshake, a two-entry skid buffer so that `in_ready` is registered, and a synchronous flush for branch squash. It sits between any two pipeline stages. Stage-specific field slicing (opcode, Rn, Rm, …) stays in the consuming stage.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_data_reg.sv | 31 +++
 rtl/pipe_stage_reg.sv | 116 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ==========================================================
// pipe_pkg : shared types and widths for elastic stages
// Rev 1.0
// ==========================================================
package pipe_pkg;

  localparam int IF_ID_W = 160;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_HALF  = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_data_reg.sv
`default_nettype none
// ==========================================================
// pipe_data_reg : payload register, load enable + sync clear
// Rev 1.0
// ==========================================================
module pipe_data_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = IF_ID_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over load so a flushed entry always reads as zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ==========================================================
// pipe_stage_reg : elastic stage register, 2-entry skid, flush
// Rev 1.0
// ==========================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = IF_ID_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipe_state_t      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q;
  logic             main_ld, main_clr, main_sel_skid;
  logic             skid_ld, skid_clr;
  logic             accept, take;

  assign out_valid = (state_q != PS_EMPTY);
  assign out_data  = main_q;
  assign in_ready  = in_ready_q;
  assign occupancy = state_q;

  always_comb begin
    accept        = in_valid & in_ready_q;
    take          = out_valid & out_ready;
    state_d       = state_q;
    main_ld       = 1'b0;
    main_clr      = 1'b0;
    main_sel_skid = 1'b0;
    skid_ld       = 1'b0;
    skid_clr      = 1'b0;
    if (flush) begin
      // A same-cycle take needs no action: the consumer already has the data.
      state_d  = PS_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (accept) begin
            state_d = PS_HALF;
            main_ld = 1'b1;
          end
        end
        PS_HALF: begin
          if (accept && take) begin
            main_ld = 1'b1;
          end else if (accept) begin
            state_d = PS_FULL;
            skid_ld = 1'b1;
          end else if (take) begin
            state_d  = PS_EMPTY;
            main_clr = 1'b1;
          end
        end
        PS_FULL: begin
          if (take) begin
            state_d       = PS_HALF;
            main_ld       = 1'b1;
            main_sel_skid = 1'b1;
            skid_clr      = 1'b1;
          end
        end
        default: begin
          state_d  = PS_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
    main_d     = main_sel_skid ? skid_q : in_data;
    in_ready_d = (state_d != PS_FULL);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= PS_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  pipe_data_reg #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .clr   (main_clr),
    .load  (main_ld),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .clr   (skid_clr),
    .load  (skid_ld),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule
`default_nettype wire
